// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: captures retired register writes into a show-ahead FIFO
// tagged with a 16-bit sequence number, counting captures dropped while full.
module wb_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int CAPTURE_R0 = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_en,
    input  logic [4:0]                wb_dest,
    input  logic [31:0]               wb_value,
    input  logic                      clear,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [15:0]               out_seq,
    output logic [4:0]                out_dest,
    output logic [31:0]               out_value,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic [7:0]                overflow_cnt
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
    localparam bit              R0_EN    = (CAPTURE_R0 != 0);

    typedef struct packed {
        logic [15:0] seq;
        logic [4:0]  dest;
        logic [31:0] value;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic [15:0]     seq_reg;
    logic [7:0]      ovf_reg;

    logic capture;
    logic pop;
    logic push;
    logic drop;

    assign capture = wb_en && ((wb_dest != 5'd0) || R0_EN);
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_FULL);
    assign pop     = !empty && out_ready;
    // A pop on the same edge frees the slot, so a full buffer still accepts the push.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    // Storage is deliberately not reset; the head is masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_reg] <= {seq_reg, wb_dest, wb_value};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            seq_reg    <= '0;
            ovf_reg    <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            seq_reg    <= '0;
            ovf_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
            // Dropped captures still consume a sequence number so loss is visible downstream.
            if (capture) begin
                seq_reg <= seq_reg + 16'd1;
            end
            if (drop && (ovf_reg != 8'hFF)) begin
                ovf_reg <= ovf_reg + 8'd1;
            end
        end
    end

    assign head         = mem[rd_ptr_reg];
    assign out_valid    = !empty;
    assign out_seq      = empty ? 16'd0 : head.seq;
    assign out_dest     = empty ? 5'd0  : head.dest;
    assign out_value    = empty ? 32'd0 : head.value;
    assign count        = count_reg;
    assign overflow_cnt = ovf_reg;

endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
- REQ-001: The module SHALL have parameter DEPTH, default 16, giving the number of FIFO entries (power of two, 4 to 256).
- REQ-002: The module SHALL have parameter CAPTURE_R0, default 0; when 1, writes to register 0 are captured.
- REQ-003: The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
- REQ-004: The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
- REQ-005: The module SHALL have port wb_en, input, 1 bit: writeback enable from the WB stage.
- REQ-006: The module SHALL have port wb_dest, input, 5 bits (REG_FILE_ADDR_LEN): writeback destination register.
- REQ-007: The module SHALL have port wb_value, input, 32 bits (WORD_LEN): writeback result.
- REQ-008: The module SHALL have port clear, input, 1 bit: synchronous flush of the buffer.
- REQ-009: The module SHALL have port out_ready, input, 1 bit: consumer accepts the head entry.
- REQ-010: The module SHALL have port out_valid, output, 1 bit: the head entry is valid.
- REQ-011: The module SHALL have port out_seq, output, 16 bits: sequence number of the head entry.
- REQ-012: The module SHALL have port out_dest, output, 5 bits: destination register of the head entry.
- REQ-013: The module SHALL have port out_value, output, 32 bits: value of the head entry.
- REQ-014: The module SHALL have port count, output, clog2(DEPTH)+1 bits: number of stored entries.
- REQ-015: The module SHALL have ports full and empty, outputs, 1 bit each: FIFO status flags.
- REQ-016: The module SHALL have port overflow_cnt, output, 8 bits: number of dropped captures.

Function
- REQ-017: A capture SHALL be qualifying in a cycle when wb_en=1 and either wb_dest!=0 or CAPTURE_R0=1.
- REQ-018: Each qualifying capture SHALL be assigned the current sequence counter value, after which the counter increments by 1, wrapping from 0xFFFF to 0x0000. This applies to dropped captures too, so loss shows up as a sequence gap.
- REQ-019: A qualifying capture SHALL write {seq, wb_dest, wb_value} at the tail on the rising edge, with out_valid high from that edge (latency 1 cycle from an empty buffer).
- REQ-020: The FIFO SHALL be show-ahead: out_seq, out_dest and out_value present the head entry combinationally from storage whenever out_valid=1, and are 0 when empty.
- REQ-021: A pop SHALL occur on an edge where out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
- REQ-022: The outputs SHALL satisfy out_valid = ~empty, empty = (count==0) and full = (count==DEPTH).
- REQ-023: Push and pop on the same edge SHALL leave count unchanged, including when full (push accepted because the pop frees a slot).
- REQ-024: A qualifying capture while full with no pop on the same edge SHALL be dropped, FIFO contents unchanged, and overflow_cnt SHALL increment, saturating at 255.
- REQ-025: Read and write pointers SHALL wrap modulo DEPTH.
- REQ-026: clear=1 SHALL, at the edge, empty the FIFO and zero the sequence counter and overflow_cnt. Clear has priority over a simultaneous push or pop, and a capture in that cycle is discarded.
- REQ-027: Entries SHALL be delivered in capture order with no duplication.

Reset
- REQ-028: rst=0 SHALL immediately, without waiting for a clock edge, force count=0, empty=1, full=0, out_valid=0, overflow_cnt=0, sequence counter=0, and out_seq/out_dest/out_value=0.
- REQ-029: Reset asserted mid-operation SHALL discard all stored entries. The first qualifying capture after deassertion SHALL carry seq 0.
- REQ-030: Storage array contents need not be reset; out_* data SHALL be masked to 0 while empty.

Verification
- REQ-031: Capture wb_en=1, dest=5, value=0xDEADBEEF with out_ready=0 -> after the edge: out_valid=1, out_seq=0, out_dest=5, out_value=0xDEADBEEF, count=1.
- REQ-032: wb_en=1, dest=0, CAPTURE_R0=0 -> count stays 0 and the next capture carries seq 0.
- REQ-033: 16 captures with out_ready=0, then a 17th -> full=1, overflow_cnt=1, head seq=0. Then drain with out_ready=1 -> seq 0..15 in order, then empty=1.
- REQ-034: Full buffer, capture plus out_ready=1 on the same edge -> count stays 16, and the new entry's seq is one past the last stored entry's seq.
- REQ-035: 300 dropped captures while full -> overflow_cnt=255. clear=1 -> count=0 and overflow_cnt=0.
- REQ-036: Assert rst low between edges with 3 entries stored -> out_valid=0 and count=0 before the next edge; the next capture after release carries seq 0.
